// File: rtl/sample_capture.sv
// Acquisition stage of the logic analyzer: synchronises the probe inputs and samples them at a
// programmable rate. It stores a pre-/post-trigger window in a ring buffer, and the display path
// reads that window by logical sample index.
module sample_capture #(
    parameter int unsigned NUM_CHAN = 10,
    parameter int unsigned DEPTH    = 640,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned PRE_TRIG = 64,
    parameter int unsigned DIV_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CHAN-1:0] chan_in,
    input  logic [NUM_CHAN-1:0] chan_enable,
    input  logic                arm,
    input  logic [3:0]          trig_chan,
    input  logic [1:0]          trig_mode,
    input  logic [DIV_W-1:0]    sample_div,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [NUM_CHAN-1:0] rd_data,
    output logic                busy,
    output logic                triggered,
    output logic                done
);

    // Samples written after the trigger sample to complete the window.
    localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;

    localparam logic [ADDR_W+1:0] DEPTH_X  = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_X2 = (ADDR_W+2)'(2 * DEPTH);
    localparam logic [ADDR_W+1:0] OFFS_X   = (ADDR_W+2)'(DEPTH - PRE_TRIG);

    typedef enum logic [2:0] {StIdle, StPre, StWaitTrig, StPost, StDone} state_e;

    state_e              state_q;
    logic [NUM_CHAN-1:0] sync1_q, sync2_q;
    logic [DIV_W-1:0]    div_q;
    logic [ADDR_W-1:0]   wr_ptr_q, trig_addr_q, n_q;
    logic                prev_q;
    logic [NUM_CHAN-1:0] mem [DEPTH];

    logic [NUM_CHAN-1:0] sample;
    logic [15:0]         sample_ext;
    logic                tick, cur_bit, edge_hit, capturing, do_write;
    logic [ADDR_W-1:0]   wr_ptr_nxt, phys;
    logic [ADDR_W+1:0]   phys_sum, rd_addr_x;

    // Two-flop synchroniser for the asynchronous probe inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= chan_in;
            sync2_q <= sync1_q;
        end
    end

    // Sample-rate divider: tick on count == sample_div, restarted by arm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (arm || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Sample masking, trigger-edge detection, write enable and read address mapping.
    always_comb begin
        tick       = (div_q == sample_div);
        sample     = sync2_q & chan_enable;
        // Channels beyond NUM_CHAN read as 0 so their edges never match.
        sample_ext = '0;
        sample_ext[NUM_CHAN-1:0] = sample;
        cur_bit    = sample_ext[trig_chan];
        case (trig_mode)
            2'b00:   edge_hit = cur_bit & ~prev_q;
            2'b01:   edge_hit = ~cur_bit & prev_q;
            2'b10:   edge_hit = cur_bit ^ prev_q;
            default: edge_hit = 1'b1;
        endcase
        capturing  = (state_q == StPre) || (state_q == StWaitTrig) || (state_q == StPost);
        do_write   = tick && capturing && !arm;
        wr_ptr_nxt = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;

        // Logical index 0 is PRE_TRIG samples before the trigger, modulo DEPTH.
        rd_addr_x  = (ADDR_W+2)'(rd_addr);
        phys_sum   = (ADDR_W+2)'(trig_addr_q) + OFFS_X + rd_addr_x;
        if (phys_sum >= DEPTH_X2) begin
            phys = ADDR_W'(phys_sum - DEPTH_X2);
        end else if (phys_sum >= DEPTH_X) begin
            phys = ADDR_W'(phys_sum - DEPTH_X);
        end else begin
            phys = ADDR_W'(phys_sum);
        end
    end

    // Capture FSM with registered status outputs; arm restarts from any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            n_q         <= '0;
            prev_q      <= 1'b0;
            busy        <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
        end else if (arm) begin
            state_q   <= StPre;
            wr_ptr_q  <= '0;
            n_q       <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
        end else if (tick) begin
            case (state_q)
                StPre: begin
                    wr_ptr_q <= wr_ptr_nxt;
                    prev_q   <= cur_bit;
                    if (n_q == ADDR_W'(PRE_TRIG - 1)) begin
                        state_q <= StWaitTrig;
                        n_q     <= '0;
                    end else begin
                        n_q <= n_q + 1'b1;
                    end
                end
                StWaitTrig: begin
                    wr_ptr_q <= wr_ptr_nxt;
                    prev_q   <= cur_bit;
                    if (edge_hit) begin
                        trig_addr_q <= wr_ptr_q;
                        triggered   <= 1'b1;
                        n_q         <= '0;
                        if (POST_N == 0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= StPost;
                        end
                    end
                end
                StPost: begin
                    wr_ptr_q <= wr_ptr_nxt;
                    prev_q   <= cur_bit;
                    if (n_q == ADDR_W'(POST_N - 1)) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        n_q <= n_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= sample;
        end
    end

    // Registered read port; same-cycle write to the same address returns old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_addr_x >= DEPTH_X) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[phys];
        end
    end

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: directed read tables, hand-written reset/re-arm sequences, and
// randomised captures checked against a window model built from the recorded input history.
module tb_sample_capture;

    localparam int DEPTH  = 640;
    localparam int PRE    = 64;
    localparam int POST_N = DEPTH - PRE - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] chan_in = '0;
    logic [9:0] chan_enable = '1;
    logic       arm = 1'b0;
    logic [3:0] trig_chan = '0;
    logic [1:0] trig_mode = '0;
    logic [15:0] sample_div = '0;
    logic [9:0] rd_addr = '0;
    logic [9:0] rd_data;
    logic       busy, triggered, done;

    sample_capture dut (
        .clk(clk), .reset(reset), .chan_in(chan_in), .chan_enable(chan_enable), .arm(arm),
        .trig_chan(trig_chan), .trig_mode(trig_mode), .sample_div(sample_div),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .triggered(triggered), .done(done)
    );

    always #5 clk = ~clk;

    // hist[e] is chan_in as seen at rising edge number e.
    int         cyc = 0;
    logic [9:0] hist [0:65535];
    always @(posedge clk) begin
        if (cyc < 65536) hist[cyc] = chan_in;
        cyc = cyc + 1;
    end

    int passed = 0;
    int total  = 0;
    bit rand_chan = 1'b0;
    int rise_cyc  = -1;

    typedef struct {
        logic [9:0] addr;
        logic [9:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic step();
        @(negedge clk);
        if (rand_chan) chan_in = 10'($urandom);
        if (rise_cyc >= 0 && cyc == rise_cyc) chan_in = 10'h008;
    endtask

    // Arm a capture, wait for done, then compare done timing and the whole window with a model:
    // tick j after the arm edge a lands on edge a+(div+1)*j and stores the input from two edges
    // earlier; the window is the DEPTH samples starting PRE before the first trigger tick.
    task automatic run_capture(input int div, input int mode, input int tc, input logic [9:0] en,
                               input int rise_off);
        int a, n, bound, jmax, t, e, now, exp_done_cyc;
        bit exp_done;
        logic [9:0] s [0:2047];
        logic [9:0] v;
        logic cb, pb, hit;
        step();
        sample_div = 16'(div);
        trig_mode  = 2'(mode);
        trig_chan  = 4'(tc);
        chan_enable = en;
        arm = 1'b1;
        a = cyc;
        rise_cyc = (rise_off >= 0) ? a + rise_off : -1;
        step();
        arm = 1'b0;
        bound = (div + 1) * (DEPTH + 300);
        n = 0;
        while (!done && n < bound) begin
            step();
            n++;
        end
        now = cyc;
        jmax = 0;
        for (int j = 1; j < 2048; j++) begin
            e = a + (div + 1) * j;
            if (e - 2 >= now) break;
            s[j] = hist[e - 2] & en;
            jmax = j;
        end
        t = -1;
        for (int j = PRE + 1; j <= jmax; j++) begin
            v = s[j];
            cb = (tc < 10) ? v[tc[3:0]] : 1'b0;
            v = s[j - 1];
            pb = (tc < 10) ? v[tc[3:0]] : 1'b0;
            case (mode)
                0: hit = cb && !pb;
                1: hit = !cb && pb;
                2: hit = cb != pb;
                default: hit = 1'b1;
            endcase
            if (hit) begin
                t = j;
                break;
            end
        end
        exp_done_cyc = a + (div + 1) * (t + POST_N) + 1;
        exp_done = (t > 0) && (exp_done_cyc <= now);
        check("done_seen", 32'(done), 32'(exp_done));
        if (done && exp_done) begin
            check("done_cycle", now, exp_done_cyc);
            check("done_triggered", 32'(triggered), 1);
            check("done_busy", 32'(busy), 0);
            for (int i = 0; i < DEPTH; i++) begin
                rd_addr = 10'(i);
                step();
                check("rd_window", 32'(rd_data), 32'(s[t - PRE + i]));
            end
        end
        rise_cyc = -1;
    endtask

    initial begin
        tbl[0] = '{10'd0,    10'h000};
        tbl[1] = '{10'd63,   10'h000};
        tbl[2] = '{10'd64,   10'h008};
        tbl[3] = '{10'd65,   10'h008};
        tbl[4] = '{10'd639,  10'h008};
        tbl[5] = '{10'd640,  10'h000};
        tbl[6] = '{10'd700,  10'h000};
        tbl[7] = '{10'd1023, 10'h000};

        // Reset state.
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_triggered", 32'(triggered), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        repeat (3) step();
        reset = 1'b1;
        step();

        // ch3 rises on the 100th WAIT_TRIG tick (overall tick 164 -> input at edge a+162).
        rand_chan = 1'b0;
        chan_in = '0;
        run_capture(0, 0, 3, 10'h3ff, 162);
        for (int i = 0; i < 8; i++) begin
            rd_addr = tbl[i].addr;
            step();
            check("rd_table", 32'(rd_data), 32'(tbl[i].exp));
        end

        // Immediate trigger, divided clock: one write per 4 clocks.
        rand_chan = 1'b1;
        run_capture(0, 3, 0, 10'h3ff, -1);
        run_capture(3, 3, 5, 10'h3ff, -1);

        // Reset in POST aborts; arm afterwards restarts.
        sample_div = '0;
        trig_mode = 2'b11;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (100) step();
        check("post_triggered", 32'(triggered), 1);
        check("post_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_triggered", 32'(triggered), 0);
        check("abort_rd_data", 32'(rd_data), 0);
        step();
        reset = 1'b1;
        step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_busy", 32'(busy), 1);

        // Arm during POST restarts the capture.
        repeat (100) step();
        check("post2_triggered", 32'(triggered), 1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("restart_triggered", 32'(triggered), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_done", 32'(done), 0);

        // Out-of-range trigger channel never fires in mode 00.
        rand_chan = 1'b0;
        chan_in = 10'h3ff;
        chan_enable = 10'h001;
        trig_chan = 4'd12;
        trig_mode = 2'b00;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (1500) step();
        check("never_done", 32'(done), 0);
        check("never_busy", 32'(busy), 1);
        check("never_triggered", 32'(triggered), 0);

        // Channel masking: only ch0 is stored.
        run_capture(0, 3, 0, 10'h001, -1);
        rd_addr = 10'd5;
        step();
        check("mask_rd", 32'(rd_data), 32'h001);

        // Randomised captures.
        rand_chan = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int tc;
            logic [9:0] en;
            tc = int'($urandom_range(0, 9));
            en = 10'($urandom) | (10'h001 << tc);
            run_capture(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), tc, en, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
